mat_add: RTL

- Element-wise IEEE-754 single-precision addition (or subtraction) of two M x N matrices: C = A + B, or C = A - B when SUB=1.
- Sits directly downstream of mat_mul_scalar in the weight-update datapath (W - lr*grad).
- Port B takes output_mat / output_mat_stb / output_mat_ack of mat_mul_scalar unchanged.
- Uses N_ADDERS time-shared instances of the team's stb/ack single-precision float adder core.

---
 rtl/mat_add.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mat_add.sv
// Element-wise float32 matrix add/subtract (C = A +/- B) using a pool of
// time-shared stb/ack adder cores, processed in batches of N_ADDERS elements.

module adder (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic [31:0] input_b,
  input  logic        input_stb,
  output logic        input_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);
  typedef enum logic [2:0] {A_IDLE, A_ALIGN, A_NORM, A_PACK, A_PUT} astate_t;
  astate_t st, st_nx;

  logic [31:0] a_r, b_r, z_r, spec_z, pack_z;
  logic [26:0] m_r, m_n, xa, xb, x, y, ys;
  logic [9:0]  e_r, e_n, ex_a, ex_b, ex, d, e_p;
  logic [7:0]  ea, eb;
  logic [4:0]  sh;
  logic [27:0] sum;
  logic [24:0] mr;
  logic [22:0] frac;
  logic        s_r, sx, sy, a_big, a_nan, b_nan, a_inf, b_inf, is_special;
  logic        sum_zero, z_sign, do_shift, rnd;

  assign input_ack    = (st == A_IDLE);
  assign output_z_stb = (st == A_PUT);
  assign output_z     = z_r;

  // Align the smaller operand (guard/round/sticky kept in the low 3 bits) and add.
  always_comb begin
    ea    = a_r[30:23];
    eb    = b_r[30:23];
    a_nan = (ea == 8'hFF) && (a_r[22:0] != '0);
    b_nan = (eb == 8'hFF) && (b_r[22:0] != '0);
    a_inf = (ea == 8'hFF) && (a_r[22:0] == '0);
    b_inf = (eb == 8'hFF) && (b_r[22:0] == '0);
    is_special = a_nan || b_nan || a_inf || b_inf;
    if (a_nan || b_nan || (a_inf && b_inf && (a_r[31] != b_r[31])))
      spec_z = 32'h7FC00000;
    else if (a_inf)
      spec_z = a_r;
    else
      spec_z = b_r;
    xa    = {ea != 8'h00, a_r[22:0], 3'b000};
    xb    = {eb != 8'h00, b_r[22:0], 3'b000};
    ex_a  = (ea == 8'h00) ? 10'd1 : {2'b00, ea};
    ex_b  = (eb == 8'h00) ? 10'd1 : {2'b00, eb};
    a_big = (ex_a > ex_b) || ((ex_a == ex_b) && (xa >= xb));
    x     = a_big ? xa : xb;
    y     = a_big ? xb : xa;
    sx    = a_big ? a_r[31] : b_r[31];
    sy    = a_big ? b_r[31] : a_r[31];
    ex    = a_big ? ex_a : ex_b;
    d     = a_big ? (ex_a - ex_b) : (ex_b - ex_a);
    sh    = '0;
    if (d >= 10'd27) begin
      ys = {26'b0, y != '0};
    end else begin
      sh = d[4:0];
      ys = (y >> sh) | {26'b0, |(y & ~({27{1'b1}} << sh))};
    end
    sum      = (sx == sy) ? ({1'b0, x} + {1'b0, ys}) : ({1'b0, x} - {1'b0, ys});
    sum_zero = (sum == '0);
    z_sign   = (sx == sy) ? sx : 1'b0;
    if (sum[27]) begin
      m_n = {sum[27:2], |sum[1:0]};
      e_n = ex + 10'd1;
    end else begin
      m_n = sum[26:0];
      e_n = ex;
    end
  end

  // Round-to-nearest-even and pack; an exponent field of 0 marks a denormal.
  always_comb begin
    do_shift = !m_r[26] && (e_r > 10'd1);
    rnd      = m_r[2] && ((|m_r[1:0]) || m_r[3]);
    mr       = {1'b0, m_r[26:3]} + {24'b0, rnd};
    e_p      = e_r;
    frac     = mr[22:0];
    if (mr[24]) begin
      e_p  = e_r + 10'd1;
      frac = '0;
    end
    if (e_p >= 10'd255)
      pack_z = {s_r, 8'hFF, 23'b0};
    else if (!mr[24] && !mr[23])
      pack_z = {s_r, 8'h00, frac};
    else
      pack_z = {s_r, e_p[7:0], frac};
  end

  always_comb begin
    st_nx = st;
    case (st)
      A_IDLE:  if (input_stb) st_nx = A_ALIGN;
      A_ALIGN: st_nx = (is_special || sum_zero) ? A_PUT : A_NORM;
      A_NORM:  if (!do_shift) st_nx = A_PACK;
      A_PACK:  st_nx = A_PUT;
      A_PUT:   if (output_z_ack) st_nx = A_IDLE;
      default: st_nx = A_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st <= A_IDLE;
    end else begin
      st <= st_nx;
      case (st)
        A_IDLE: if (input_stb) begin
          a_r <= input_a;
          b_r <= input_b;
        end
        A_ALIGN: begin
          m_r <= m_n;
          e_r <= e_n;
          s_r <= sx;
          z_r <= is_special ? spec_z : {z_sign, 31'b0};
        end
        A_NORM: if (do_shift) begin
          m_r <= {m_r[25:0], 1'b0};
          e_r <= e_r - 10'd1;
        end
        A_PACK:  z_r <= pack_z;
        default: ;
      endcase
    end
  end
endmodule

module mat_add #(
  parameter int M        = 2,
  parameter int N        = 3,
  parameter int N_ADDERS = 4,
  parameter int SUB      = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [M-1:0][N-1:0][31:0]   input_a_mat,
  input  logic                        input_a_stb,
  output logic                        input_a_ack,
  input  logic [M-1:0][N-1:0][31:0]   input_b_mat,
  input  logic                        input_b_stb,
  output logic                        input_b_ack,
  output logic [M-1:0][N-1:0][31:0]   output_mat,
  output logic                        output_mat_stb,
  input  logic                        output_mat_ack
);
  localparam int unsigned TOTAL = M * N;
  localparam int unsigned NA    = (N_ADDERS < 1) ? 1 :
                                  (N_ADDERS > TOTAL) ? TOTAL : N_ADDERS;
  localparam int unsigned NB    = (TOTAL + NA - 1) / NA;
  localparam int unsigned BW    = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned IW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  typedef enum logic [1:0] {IDLE, COMPUTE, OUTPUT} state_t;
  state_t state, state_nx;

  logic [BW-1:0]             batch;
  logic [NA-1:0]             issued, done, active;
  logic [NA-1:0]             add_in_stb, add_in_ack, add_out_stb, add_out_ack;
  logic [NA-1:0][IW-1:0]     idx;
  logic [NA-1:0][31:0]       add_a, add_b, add_z;
  logic [TOTAL-1:0][31:0]    a_reg, b_reg, res, res_nx, out_r;
  logic                      in_ack_r, out_stb_r, capture, batch_done, last_batch, fin;
  int unsigned               k;

  assign input_a_ack    = in_ack_r;
  assign input_b_ack    = in_ack_r;
  assign output_mat_stb = out_stb_r;
  assign output_mat     = out_r;

  for (genvar g = 0; g < NA; g++) begin : g_add
    adder u_adder (
      .clk(clk), .rst(rst),
      .input_a(add_a[g]), .input_b(add_b[g]),
      .input_stb(add_in_stb[g]), .input_ack(add_in_ack[g]),
      .output_z(add_z[g]), .output_z_stb(add_out_stb[g]), .output_z_ack(add_out_ack[g])
    );
  end

  // Results are folded into res_nx on the cycle they arrive so the last batch
  // can be copied to the output register on the same edge that enters OUTPUT.
  always_comb begin
    capture    = in_ack_r && input_a_stb && input_b_stb;
    last_batch = (batch == BW'(NB - 1));
    batch_done = 1'b1;
    res_nx     = res;
    k          = 0;
    for (int unsigned a = 0; a < NA; a++) begin
      k              = 32'(batch) * NA + a;
      active[a]      = (k < TOTAL);
      idx[a]         = active[a] ? IW'(k) : '0;
      add_a[a]       = a_reg[idx[a]];
      add_b[a]       = b_reg[idx[a]] ^ {SUB != 0, 31'b0};
      add_in_stb[a]  = (state == COMPUTE) && active[a] && !issued[a];
      add_out_ack[a] = (state == COMPUTE) && active[a] && !done[a];
      fin            = add_out_stb[a] && (state == COMPUTE) && active[a] && !done[a];
      if (fin)
        res_nx[idx[a]] = add_z[a];
      if (active[a] && !done[a] && !fin)
        batch_done = 1'b0;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (capture) state_nx = COMPUTE;
      COMPUTE: if (batch_done && last_batch) state_nx = OUTPUT;
      OUTPUT:  if (output_mat_ack) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      batch     <= '0;
      issued    <= '0;
      done      <= '0;
      in_ack_r  <= 1'b0;
      out_stb_r <= 1'b0;
      out_r     <= '0;
      res       <= '0;
    end else begin
      state     <= state_nx;
      in_ack_r  <= (state_nx == IDLE);
      out_stb_r <= (state_nx == OUTPUT);
      if (capture) begin
        a_reg  <= input_a_mat;
        b_reg  <= input_b_mat;
        batch  <= '0;
        issued <= '0;
        done   <= '0;
      end
      if (state == COMPUTE) begin
        res <= res_nx;
        if (batch_done) begin
          issued <= '0;
          done   <= '0;
          if (!last_batch)
            batch <= batch + BW'(1);
          else
            out_r <= res_nx;
        end else begin
          for (int unsigned a = 0; a < NA; a++) begin
            if (add_in_stb[a] && add_in_ack[a])
              issued[a] <= 1'b1;
            if (add_out_stb[a] && add_out_ack[a])
              done[a] <= 1'b1;
          end
        end
      end
    end
  end
endmodule
